ub_fifo_loader: RTL and testbench

UB_FIFO_LOADER -- requirements
Module: ub_fifo_loader

---
 rtl/ub_fifo_loader_if.sv | 27 ++
 rtl/ub_fifo_loader.sv | 128 ++++++++++++
 tb/tb_ub_fifo_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ub_fifo_loader_if.sv
// Host FIFO byte handshake plus unified-buffer write port, bundled for the loader.
interface ub_fifo_loader_if #(
  parameter int unsigned ADDRESS_SIZE    = 10,
  parameter int unsigned FIFO_DATA_WIDTH = 8
);
  logic                       fifo_valid;
  logic [FIFO_DATA_WIDTH-1:0] fifo_data;
  logic                       fifo_ready;
  logic                       ub_we;
  logic                       ub_fifo_en;
  logic                       ub_section;
  logic [ADDRESS_SIZE-1:0]    ub_address;
  logic [FIFO_DATA_WIDTH-1:0] ub_fifo_in;
  logic                       ub_done;

  // Loader side: consumes FIFO bytes, drives buffer writes.
  modport master (
    input  fifo_valid, fifo_data, ub_done,
    output fifo_ready, ub_we, ub_fifo_en, ub_section, ub_address, ub_fifo_in
  );

  // Environment side: host FIFO and unified buffer.
  modport slave (
    output fifo_valid, fifo_data, ub_done,
    input  fifo_ready, ub_we, ub_fifo_en, ub_section, ub_address, ub_fifo_in
  );
endinterface

// File: rtl/ub_fifo_loader.sv
// Streams host FIFO bytes into the unified buffer, two bytes per word
// (low half first), one buffer write per byte acknowledged by ub_done.
module ub_fifo_loader #(
  parameter int unsigned BUFFER_SIZE     = 1024,
  parameter int unsigned FIFO_DATA_WIDTH = 8,
  parameter int unsigned ADDRESS_SIZE    = $clog2(BUFFER_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDRESS_SIZE-1:0] base_addr,
  input  logic [ADDRESS_SIZE:0]   num_words,
  output logic                    busy,
  output logic                    load_done,
  output logic                    err_range,
  ub_fifo_loader_if.master        bus
);

  localparam logic [ADDRESS_SIZE+1:0] BufLimit = (ADDRESS_SIZE+2)'(BUFFER_SIZE);

  typedef enum logic [2:0] {StIdle, StGetByte, StWrite, StWaitAck, StFinish} state_e;

  state_e                     state_q, state_d;
  logic [ADDRESS_SIZE-1:0]    address_q, address_d;
  logic [ADDRESS_SIZE:0]      remaining_q, remaining_d;
  logic                       section_q, section_d;
  logic [FIFO_DATA_WIDTH-1:0] byte_q, byte_d;
  logic                       err_q, err_d;
  logic [ADDRESS_SIZE+1:0]    end_addr;

  // One past the last word of the requested load, wide enough not to overflow.
  assign end_addr = {2'b00, base_addr} + {1'b0, num_words};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      address_q   <= '0;
      remaining_q <= '0;
      section_q   <= 1'b0;
      byte_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      remaining_q <= remaining_d;
      section_q   <= section_d;
      byte_q      <= byte_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic and all outputs, decoded from the current state.
  always_comb begin
    state_d        = state_q;
    address_d      = address_q;
    remaining_d    = remaining_q;
    section_d      = section_q;
    byte_d         = byte_q;
    err_d          = err_q;
    bus.fifo_ready = 1'b0;
    bus.ub_we      = 1'b0;
    bus.ub_fifo_en = 1'b0;
    bus.ub_section = 1'b0;
    bus.ub_address = '0;
    bus.ub_fifo_in = '0;
    load_done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_words == '0) begin
            state_d = StFinish;
          end else if (end_addr > BufLimit) begin
            err_d = 1'b1;
          end else begin
            address_d   = base_addr;
            remaining_d = num_words;
            section_d   = 1'b0;
            err_d       = 1'b0;
            state_d     = StGetByte;
          end
        end
      end
      StGetByte: begin
        bus.fifo_ready = 1'b1;
        if (bus.fifo_valid) begin
          byte_d  = bus.fifo_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        bus.ub_we      = 1'b1;
        bus.ub_fifo_en = 1'b1;
        bus.ub_section = section_q;
        bus.ub_address = address_q;
        bus.ub_fifo_in = byte_q;
        state_d        = StWaitAck;
      end
      StWaitAck: begin
        if (bus.ub_done) begin
          section_d = ~section_q;
          if (section_q) begin
            remaining_d = remaining_q - (ADDRESS_SIZE+1)'(1);
            if (remaining_q == (ADDRESS_SIZE+1)'(1)) begin
              // Last word: leave the address on it so it never steps past the buffer end.
              state_d = StFinish;
            end else begin
              address_d = address_q + ADDRESS_SIZE'(1);
              state_d   = StGetByte;
            end
          end else begin
            state_d = StGetByte;
          end
        end
      end
      StFinish: begin
        load_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign err_range = err_q;

endmodule

// File: tb/tb_ub_fifo_loader.sv
// Directed bench for ub_fifo_loader with a small buffer-ack model and write logger.
module tb_ub_fifo_loader;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          busy, load_done, err_range;

  ub_fifo_loader_if #(.ADDRESS_SIZE(AW), .FIFO_DATA_WIDTH(DW)) bus ();

  ub_fifo_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .load_done (load_done),
    .err_range (err_range),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ack_delay = 1;
  int ack_cnt = 0;
  int done_cnt = 0;
  int ready_cnt = 0;
  int ready_drops = 0;
  logic prev_ready = 1'b0;
  logic prev_valid = 1'b0;
  logic [18:0] wr_q[$];
  int          wr_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: ub_done rises ack_delay cycles after a write cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_cnt <= 0;
    else if (bus.ub_we) ack_cnt <= ack_delay;
    else if (ack_cnt != 0) ack_cnt <= ack_cnt - 1;
  end
  assign bus.ub_done = (ack_cnt == 1);

  // Monitor samples mid low-phase, after the negedge drivers have settled.
  always begin
    @(negedge clk);
    #2;
    if (bus.ub_we) begin
      wr_q.push_back({bus.ub_address, bus.ub_section, bus.ub_fifo_in});
      wr_t.push_back(cyc);
    end
    if (load_done) done_cnt++;
    if (bus.fifo_ready) ready_cnt++;
    if (prev_ready && !prev_valid && !bus.fifo_ready && rst_n) ready_drops++;
    prev_ready = bus.fifo_ready;
    prev_valid = bus.fifo_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ctl"}, {25'd0, busy, load_done, err_range, bus.fifo_ready, bus.ub_we,
                              bus.ub_fifo_en, bus.ub_section}, 32'd0);
    check_eq({tag, "_addr"}, 32'(bus.ub_address), 32'd0);
    check_eq({tag, "_data"}, 32'(bus.ub_fifo_in), 32'd0);
  endtask

  task automatic start_load(input logic [AW-1:0] b, input logic [AW:0] n);
    @(negedge clk);
    start = 1'b1; base_addr = b; num_words = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    int n = 0;
    bus.fifo_valid = 1'b1;
    bus.fifo_data  = d;
    while (!bus.fifo_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("ready_timeout", 32'(bus.fifo_ready), 32'd1);
    @(negedge clk);
    bus.fifo_valid = 1'b0;
    bus.fifo_data  = '0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int base_cnt);
    int n = 0;
    while (done_cnt == base_cnt && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_eq({tag, "_done_pulses"}, 32'(done_cnt - base_cnt), 32'd1);
    check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_writes(input int cnt);
    int n = 0;
    while (wr_q.size() < cnt && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("write_wait", 32'(wr_q.size()), 32'(cnt));
  endtask

  task automatic clear_log();
    wr_q.delete();
    wr_t.delete();
  endtask

  int d0, r0, w0;

  initial begin
    bus.fifo_valid = 1'b0;
    bus.fifo_data  = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;

    // Back-to-back stream of two words.
    clear_log(); d0 = done_cnt;
    start_load(10'h010, 11'd2);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    wait_done("stream", d0);
    check_eq("stream_count", 32'(wr_q.size()), 32'd4);
    if (wr_q.size() == 4) begin
      check_eq("stream_w0", 32'(wr_q[0]), 32'({10'h010, 1'b0, 8'hAA}));
      check_eq("stream_w1", 32'(wr_q[1]), 32'({10'h010, 1'b1, 8'hBB}));
      check_eq("stream_w2", 32'(wr_q[2]), 32'({10'h011, 1'b0, 8'hCC}));
      check_eq("stream_w3", 32'(wr_q[3]), 32'({10'h011, 1'b1, 8'hDD}));
      check_eq("stream_rate", 32'(wr_t[3] - wr_t[0]), 32'd9);
    end

    // Same load with 5-cycle stalls; ready must stay up until a byte arrives.
    clear_log(); d0 = done_cnt; ready_drops = 0;
    start_load(10'h010, 11'd2);
    send_byte(8'hAA, 5); send_byte(8'hBB, 5); send_byte(8'hCC, 5); send_byte(8'hDD, 5);
    wait_done("stall", d0);
    check_eq("stall_ready_drops", 32'(ready_drops), 32'd0);
    check_eq("stall_count", 32'(wr_q.size()), 32'd4);
    if (wr_q.size() == 4) begin
      check_eq("stall_w0", 32'(wr_q[0]), 32'({10'h010, 1'b0, 8'hAA}));
      check_eq("stall_w3", 32'(wr_q[3]), 32'({10'h011, 1'b1, 8'hDD}));
    end

    // Range error, then a load ending exactly at the last word.
    clear_log();
    start_load(10'd1022, 11'd3);
    check_eq("range_err_set", 32'(err_range), 32'd1);
    check_eq("range_err_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("range_err_nowrite", 32'(wr_q.size()), 32'd0);
    d0 = done_cnt;
    start_load(10'd1022, 11'd2);
    check_eq("range_err_clear", 32'(err_range), 32'd0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    wait_done("range_ok", d0);
    check_eq("range_ok_count", 32'(wr_q.size()), 32'd4);
    if (wr_q.size() == 4) begin
      check_eq("range_ok_w0", 32'(wr_q[0]), 32'({10'd1022, 1'b0, 8'h11}));
      check_eq("range_ok_last", 32'(wr_q[3]), 32'({10'd1023, 1'b1, 8'h44}));
    end

    // Zero-length load.
    clear_log(); d0 = done_cnt; r0 = ready_cnt;
    start_load(10'h055, 11'd0);
    check_eq("zero_done_hi", 32'(load_done), 32'd1);
    @(negedge clk);
    check_eq("zero_done_lo", 32'(load_done), 32'd0);
    check_eq("zero_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("zero_nowrite", 32'(wr_q.size()), 32'd0);
    check_eq("zero_noready", 32'(ready_cnt - r0), 32'd0);
    check_eq("zero_pulses", 32'(done_cnt - d0), 32'd1);

    // Slow acknowledge: hold in WAIT_ACK with ready low.
    clear_log(); d0 = done_cnt; ack_delay = 4;
    start_load(10'h100, 11'd1);
    fork
      begin
        send_byte(8'h5A, 0);
        send_byte(8'hA5, 0);
      end
      begin
        wait_writes(1);
        repeat (3) begin
          check_eq("slow_ready_low", 32'(bus.fifo_ready), 32'd0);
          check_eq("slow_no_write", 32'(bus.ub_we), 32'd0);
          @(negedge clk);
        end
      end
    join
    wait_done("slow", d0);
    ack_delay = 1;
    check_eq("slow_count", 32'(wr_q.size()), 32'd2);
    if (wr_q.size() == 2) begin
      check_eq("slow_gap", 32'(wr_t[1] - wr_t[0]), 32'd6);
      check_eq("slow_w1", 32'(wr_q[1]), 32'({10'h100, 1'b1, 8'hA5}));
    end

    // Reset mid-load, with a stray start while busy.
    clear_log(); d0 = done_cnt;
    start_load(10'h020, 11'd4);
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    start_load(10'h300, 11'd1);
    send_byte(8'h03, 0);
    wait_writes(3);
    if (wr_q.size() == 3) check_eq("abort_w2", 32'(wr_q[2]), 32'({10'h021, 1'b0, 8'h03}));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_quiet("abort_reset");
    w0 = wr_q.size();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("abort_nowrite", 32'(wr_q.size() - w0), 32'd0);
    check_eq("abort_nodone", 32'(done_cnt - d0), 32'd0);
    check_quiet("abort_idle");
    clear_log(); d0 = done_cnt;
    start_load(10'h040, 11'd1);
    send_byte(8'h5A, 0); send_byte(8'hA5, 0);
    wait_done("after_abort", d0);
    check_eq("after_abort_count", 32'(wr_q.size()), 32'd2);
    if (wr_q.size() == 2) begin
      check_eq("after_abort_w0", 32'(wr_q[0]), 32'({10'h040, 1'b0, 8'h5A}));
      check_eq("after_abort_w1", 32'(wr_q[1]), 32'({10'h040, 1'b1, 8'hA5}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
